ppl_ray_scheduler: RTL and testbench

//  Slot scheduler for the ray-march ring pipeline. Each cycle one ring slot exits the pipeline;
//  the block decides whether to recirculate it, retire it and inject a new pixel, or leave it empty.
//  It also sequences frames: latches camera params, runs the prepare window, issues pixel

---
 rtl/ppl_ray_scheduler.sv | 142 ++++++++++++++
 tb/tb_ppl_ray_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ppl_ray_scheduler.sv
// Ring-slot scheduler and frame sequencer for the ray-march pipeline.
// Optional statistics outputs are built when PPL_SCHED_STATS_EN is defined.
module ppl_ray_scheduler #(
  parameter int NUM_PIXELS     = 76800,
  parameter int ADDR_W         = 17,
  parameter int PREPARE_CYCLES = 4,
  parameter int MAX_STEPS      = 63,
  parameter int ITER_W         = 6,
  parameter int PIPE_DEPTH     = 16
) (
  input  logic                                  clk_ppl,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic                                  frame_req,
  input  logic                                  slot_valid,
  input  logic                                  slot_hit,
  input  logic [ITER_W-1:0]                     slot_iter,
  input  logic [ADDR_W-1:0]                     slot_addr,
  output logic                                  param_latch,
  output logic                                  is_preparing,
  output logic                                  inject,
  output logic [ADDR_W-1:0]                     inject_addr,
  output logic                                  recirc,
  output logic                                  retire,
  output logic [ADDR_W-1:0]                     retire_addr,
  output logic                                  retire_forced,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]       in_flight,
  output logic                                  frame_done
`ifdef PPL_SCHED_STATS_EN
  ,
  output logic [31:0]                           stat_frame_cycles,
  output logic [31:0]                           stat_ray_steps
`endif
);

  localparam int FLT_W  = $clog2(PIPE_DEPTH + 1);
  localparam int PREP_W = $clog2(PREPARE_CYCLES + 1);
  localparam logic [PREP_W-1:0] PREP_LAST = PREP_W'(PREPARE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ITER_W-1:0] ITER_CAP  = ITER_W'(MAX_STEPS);
  localparam logic [FLT_W-1:0]  FLT_MAX   = FLT_W'(PIPE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LATCH   = 3'd1,
    S_PREPARE = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t              state_r;
  logic [PREP_W-1:0]   prep_cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [FLT_W-1:0]    in_flight_r;
  logic                run_s;
  logic                live_s;
  logic                fin_s;

  assign run_s  = (state_r == S_RUN);
  // Slots are only acted on while a frame is actually marching.
  assign live_s = enable & (run_s | (state_r == S_DRAIN));
  assign fin_s  = slot_valid & (slot_hit | (slot_iter >= ITER_CAP));

  assign recirc        = live_s & slot_valid & ~fin_s;
  assign retire        = live_s & fin_s;
  assign retire_forced = retire & ~slot_hit;
  assign retire_addr   = retire ? slot_addr : {ADDR_W{1'b0}};
  assign inject        = enable & run_s & (~slot_valid | fin_s);
  assign inject_addr   = addr_r;
  assign in_flight     = in_flight_r;
  assign param_latch   = enable & (state_r == S_LATCH);
  assign is_preparing  = ~(run_s | (state_r == S_DRAIN));
  assign frame_done    = enable & (state_r == S_DRAIN) & (in_flight_r == {FLT_W{1'b0}});

  // Frame sequencer, pixel address counter and live-ray count.
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      prep_cnt_r  <= {PREP_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      in_flight_r <= {FLT_W{1'b0}};
    end else if (enable) begin
      case (state_r)
        S_IDLE: begin
          if (frame_req) begin
            state_r <= S_LATCH;
            addr_r  <= {ADDR_W{1'b0}};
          end
        end
        S_LATCH: begin
          state_r    <= S_PREPARE;
          prep_cnt_r <= {PREP_W{1'b0}};
        end
        S_PREPARE: begin
          if (prep_cnt_r == PREP_LAST) state_r <= S_RUN;
          else                         prep_cnt_r <= prep_cnt_r + PREP_W'(1);
        end
        S_RUN: begin
          // Address parks on the last pixel so it never leaves the frame.
          if (inject) begin
            if (addr_r == ADDR_LAST) state_r <= S_DRAIN;
            else                     addr_r  <= addr_r + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (in_flight_r == {FLT_W{1'b0}}) state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase

      if (inject && !retire && (in_flight_r != FLT_MAX))
        in_flight_r <= in_flight_r + FLT_W'(1);
      else if (retire && !inject && (in_flight_r != {FLT_W{1'b0}}))
        in_flight_r <= in_flight_r - FLT_W'(1);
    end
  end

`ifdef PPL_SCHED_STATS_EN
  logic [31:0] frame_cycles_r;
  logic [31:0] ray_steps_r;

  // Per-frame cycle and recirculation counters; cleared at LATCH, frozen in IDLE.
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) begin
      frame_cycles_r <= 32'd0;
      ray_steps_r    <= 32'd0;
    end else if (enable) begin
      if (state_r == S_LATCH) begin
        frame_cycles_r <= 32'd1;
        ray_steps_r    <= 32'd0;
      end else if (state_r != S_IDLE) begin
        frame_cycles_r <= frame_cycles_r + 32'd1;
        if (recirc) ray_steps_r <= ray_steps_r + 32'd1;
      end
    end
  end

  assign stat_frame_cycles = frame_cycles_r;
  assign stat_ray_steps    = ray_steps_r;
`endif

endmodule

// File: tb/tb_ppl_ray_scheduler.sv
// Scoreboard bench for ppl_ray_scheduler: random slot traffic against a frame-level reference model.
module tb_ppl_ray_scheduler;
  localparam int NPIX  = 20;
  localparam int PREP  = 4;
  localparam int DEPTH = 16;

  logic clk_ppl = 1'b0;
  always #5 clk_ppl = ~clk_ppl;

  logic        rst, enable, frame_req, slot_valid, slot_hit;
  logic [5:0]  slot_iter;
  logic [16:0] slot_addr;
  logic        param_latch, is_preparing, inject, recirc, retire, retire_forced, frame_done;
  logic [16:0] inject_addr, retire_addr;
  logic [4:0]  in_flight;
`ifdef PPL_SCHED_STATS_EN
  logic [31:0] stat_frame_cycles, stat_ray_steps;
`endif

  ppl_ray_scheduler #(.NUM_PIXELS(NPIX), .PREPARE_CYCLES(PREP), .PIPE_DEPTH(DEPTH)) dut (
    .clk_ppl(clk_ppl), .rst(rst), .enable(enable), .frame_req(frame_req),
    .slot_valid(slot_valid), .slot_hit(slot_hit), .slot_iter(slot_iter), .slot_addr(slot_addr),
    .param_latch(param_latch), .is_preparing(is_preparing), .inject(inject),
    .inject_addr(inject_addr), .recirc(recirc), .retire(retire), .retire_addr(retire_addr),
    .retire_forced(retire_forced), .in_flight(in_flight), .frame_done(frame_done)
`ifdef PPL_SCHED_STATS_EN
    , .stat_frame_cycles(stat_frame_cycles), .stat_ray_steps(stat_ray_steps)
`endif
  );

  typedef struct {
    int cyc;
    bit pl, prep, inj, rec, ret, forced, done;
    int iaddr, raddr, flight;
    int fc, rs;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  // Reference model: a frame is a count of cycles since its latch plus pixels issued and rays alive.
  bit m_active;
  int m_since, m_injected, m_live, m_fc, m_rs;

  function automatic int phase();
    if (!m_active)              return 0;
    if (m_since == 0)           return 1;
    if (m_since <= PREP)        return 2;
    if (m_injected < NPIX)      return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_active = 0; m_since = 0; m_injected = 0; m_live = 0; m_fc = 0; m_rs = 0;
  endtask

  task automatic step(input bit r, input bit en, input bit req, input bit sv,
                      input bit sh, input int it, input int sa);
    exp_t e;
    int   ph;
    bit   marching, fin;
    @(posedge clk_ppl);
    #1;
    rst = r; enable = en; frame_req = req; slot_valid = sv; slot_hit = sh;
    slot_iter = 6'(it); slot_addr = 17'(sa);
    cyc++;
    e.cyc = cyc;
    if (r) begin
      model_reset();
      e.pl = 0; e.prep = 1; e.inj = 0; e.rec = 0; e.ret = 0; e.forced = 0; e.done = 0;
      e.iaddr = 0; e.raddr = 0; e.flight = 0; e.fc = 0; e.rs = 0;
      sb.push_back(e);
      return;
    end
    ph       = phase();
    marching = en && (ph == 3 || ph == 4);
    fin      = sv && (sh || it >= 63);
    e.pl     = en && ph == 1;
    e.prep   = ph < 3;
    e.rec    = marching && sv && !fin;
    e.ret    = marching && fin;
    e.forced = e.ret && !sh;
    e.inj    = en && ph == 3 && (!sv || fin);
    e.iaddr  = (m_injected < NPIX - 1) ? m_injected : NPIX - 1;
    e.raddr  = sa;
    e.flight = m_live;
    e.done   = en && ph == 4 && m_live == 0;
    e.fc     = m_fc;
    e.rs     = m_rs;
    sb.push_back(e);
    if (en) begin
      if (ph == 0 && req) begin
        m_active = 1; m_since = 0; m_injected = 0;
      end else if (ph == 1 || ph == 2) begin
        m_since++;
      end
      if (e.inj) m_injected++;
      if (e.inj && !e.ret && m_live < DEPTH) m_live++;
      if (e.ret && !e.inj && m_live > 0)     m_live--;
      if (e.done) m_active = 0;
      if (ph == 1) begin
        m_fc = 1; m_rs = 0;
      end else if (ph != 0) begin
        m_fc++;
        if (e.rec) m_rs++;
      end
    end
  endtask

  function automatic void chk(string name, int c, int act, int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, c, act, req);
  endfunction

  // Monitor: outputs are compared mid-cycle against the oldest pending expectation.
  always @(negedge clk_ppl) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("param_latch",  e.cyc, int'(param_latch),  int'(e.pl));
      chk("is_preparing", e.cyc, int'(is_preparing), int'(e.prep));
      chk("inject",       e.cyc, int'(inject),       int'(e.inj));
      chk("inject_addr",  e.cyc, int'(inject_addr),  e.iaddr);
      chk("recirc",       e.cyc, int'(recirc),       int'(e.rec));
      chk("retire",       e.cyc, int'(retire),       int'(e.ret));
      chk("retire_forced",e.cyc, int'(retire_forced),int'(e.forced));
      if (e.ret) chk("retire_addr", e.cyc, int'(retire_addr), e.raddr);
      chk("in_flight",    e.cyc, int'(in_flight),    e.flight);
      chk("frame_done",   e.cyc, int'(frame_done),   int'(e.done));
`ifdef PPL_SCHED_STATS_EN
      chk("stat_frame_cycles", e.cyc, int'(stat_frame_cycles), e.fc);
      chk("stat_ray_steps",    e.cyc, int'(stat_ray_steps),    e.rs);
`endif
    end
  end

  initial begin
    int guard;
    bit r, en, sv, sh;
    int it;
    rst = 1'b1; enable = 1'b0; frame_req = 1'b0; slot_valid = 1'b0; slot_hit = 1'b0;
    slot_iter = 6'd0; slot_addr = 17'd0;
    model_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Empty ring: latch, prepare window, then one inject per RUN cycle.
    repeat (2 + PREP + NPIX) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    guard = 0;
    while (m_active && guard < 100) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, guard);
      guard++;
    end
    chk("frame1_drained", cyc, int'(m_active), 0);

    // Reset while draining with three rays still alive.
    repeat (2 + PREP + NPIX) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    guard = 0;
    while (m_live > 3 && guard < 100) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 63, guard);
      guard++;
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    // Random traffic: stray slots, stalls, iteration-cap retires, occasional reset.
    for (int k = 0; k < 4000; k++) begin
      r  = ($urandom_range(0, 599) == 0);
      en = ($urandom_range(0, 9) != 0);
      sv = $urandom_range(0, 1) == 1;
      sh = ($urandom_range(0, 3) == 0);
      it = ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(0, 63));
      step(r, en, ($urandom_range(0, 3) != 0), sv, sh, it, int'($urandom_range(0, 131071)));
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk_ppl);
      guard++;
    end
    #1;
    chk("scoreboard_empty", cyc, sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
